// File: rtl/cpu_loader_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_loader_defs_pkg
// Description : Shared state encoding and constants for the CPU program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_loader_defs_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } loader_state_t;

    localparam int          WORD_BYTES  = 4;
    localparam logic [31:0] ADDR_STRIDE = 32'd4;

endpackage : cpu_loader_defs_pkg
`default_nettype wire

// File: rtl/cpu_program_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_program_loader_byte_packer
// Description : Big-endian 8->32 assembler. The first three bytes of a word
//               are stored; the fourth is combined combinationally so the
//               full word is presented on the same edge it completes.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_program_loader_byte_packer
    import cpu_loader_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  r_cnt;
    logic [23:0] r_hi;

    // Store leading bytes into their big-endian lanes and advance the lane counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_hi  <= 24'd0;
        end else if (clear) begin
            r_cnt <= 2'd0;
        end else if (byte_en) begin
            case (r_cnt)
                2'd0:    r_hi[23:16] <= byte_in;
                2'd1:    r_hi[15:8]  <= byte_in;
                2'd2:    r_hi[7:0]   <= byte_in;
                default: r_hi        <= r_hi;
            endcase
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Last byte of a word completes it without an extra register stage
    always_comb begin
        word       = {r_hi, byte_in};
        word_valid = byte_en && !clear && (r_cnt == 2'(WORD_BYTES - 1));
    end

endmodule : cpu_program_loader_byte_packer
`default_nettype wire

// File: rtl/cpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : cpu_program_loader
// Description : Loads a host byte stream into CPU instruction memory through
//               the initialize interface, holding the CPU in reset while
//               loading and releasing it when the program is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_program_loader
    import cpu_loader_defs_pkg::*;
#(
    parameter int          MAX_WORDS  = 64,
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          WRITE_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_address,
    output logic [31:0] instruction_initialize_data,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int HOLD_W = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;

    loader_state_t     r_state;
    logic [6:0]        r_words;
    logic [HOLD_W-1:0] r_hold;
    logic              r_pending;

    logic              w_accept;
    logic              w_clear;
    logic [31:0]       w_word;
    logic              w_word_valid;
    logic [6:0]        w_start_words;
    logic              w_too_big;

    // Byte handshake, packer clearing on an accepted start, and the word count for a launch
    always_comb begin
        w_accept      = byte_valid && byte_ready;
        w_clear       = start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
        w_start_words = start ? num_words : r_words;
        w_too_big     = {25'd0, w_start_words} > 32'(MAX_WORDS);
    end

    cpu_program_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .byte_en    (w_accept),
        .byte_in    (byte_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    // Loader FSM with registered outputs; a start in RUN first re-asserts CPU reset,
    // then launches from IDLE using the word count captured in r_words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state                        <= ST_IDLE;
            r_words                        <= 7'd0;
            r_hold                         <= '0;
            r_pending                      <= 1'b0;
            byte_ready                     <= 1'b0;
            initialize                     <= 1'b1;
            cpu_rst                        <= 1'b1;
            instruction_initialize_address <= BASE_ADDR;
            instruction_initialize_data    <= 32'd0;
            busy                           <= 1'b0;
            done                           <= 1'b0;
            error                          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start || r_pending) begin
                        r_pending <= 1'b0;
                        if (w_too_big) begin
                            error <= 1'b1;
                        end else begin
                            error                          <= 1'b0;
                            r_words                        <= w_start_words;
                            instruction_initialize_address <= BASE_ADDR;
                            r_hold                         <= '0;
                            if (w_start_words == 7'd0) begin
                                initialize <= 1'b0;
                                cpu_rst    <= 1'b0;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                r_state    <= ST_RELEASE;
                            end else begin
                                busy       <= 1'b1;
                                byte_ready <= 1'b1;
                                r_state    <= ST_COLLECT;
                            end
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_word_valid) begin
                        instruction_initialize_data <= w_word;
                        byte_ready                  <= 1'b0;
                        r_hold                      <= '0;
                        r_state                     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_hold == HOLD_W'(WRITE_HOLD - 1)) begin
                        r_words <= r_words - 7'd1;
                        if (r_words == 7'd1) begin
                            initialize <= 1'b0;
                            cpu_rst    <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= ST_RELEASE;
                        end else begin
                            instruction_initialize_address <= instruction_initialize_address + ADDR_STRIDE;
                            byte_ready                     <= 1'b1;
                            r_state                        <= ST_COLLECT;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (start) begin
                        initialize                     <= 1'b1;
                        cpu_rst                        <= 1'b1;
                        instruction_initialize_address <= BASE_ADDR;
                        r_words                        <= num_words;
                        r_pending                      <= 1'b1;
                        r_state                        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : cpu_program_loader
`default_nettype wire

// File: tb/tb_cpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_program_loader
// Description : Directed self-checking bench for cpu_program_loader with a
//               write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        initialize;
    logic [31:0] instruction_initialize_address;
    logic [31:0] instruction_initialize_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;
    int writes = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_program_loader #(
        .MAX_WORDS  (64),
        .BASE_ADDR  (32'd0),
        .WRITE_HOLD (1)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .start                          (start),
        .num_words                      (num_words),
        .byte_valid                     (byte_valid),
        .byte_data                      (byte_data),
        .byte_ready                     (byte_ready),
        .initialize                     (initialize),
        .instruction_initialize_address (instruction_initialize_address),
        .instruction_initialize_data    (instruction_initialize_data),
        .cpu_rst                        (cpu_rst),
        .busy                           (busy),
        .done                           (done),
        .error                          (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write cycles are busy with byte_ready low; each pops one scoreboard entry
    always @(negedge clk) begin
        if (rst === 1'b0 && busy === 1'b1 && byte_ready === 1'b0) begin
            writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", instruction_initialize_address, e[63:32]);
                check("wr_data", instruction_initialize_data, e[31:0]);
                check("wr_init", {31'd0, initialize}, 32'd1);
                check("wr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            end
        end
        if (rst === 1'b0 && done === 1'b1) done_cnt++;
    end

    task automatic check_reset_values();
        check("rst_init", {31'd0, initialize}, 32'd1);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_addr", instruction_initialize_address, 32'd0);
        check("rst_data", instruction_initialize_data, 32'd0);
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
    endtask

    // Called at a negedge; returns at a negedge
    task automatic pulse_start(input logic [6:0] n);
        start = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        byte_valid = 1'b1;
        byte_data = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data = 8'hxx;
        if (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] a, input bit gap);
        exp_q.push_back({a, w});
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("rel_init", {31'd0, initialize}, 32'd0);
        check("rel_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("rel_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("run_init", {31'd0, initialize}, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int d0;
        int w0;
        rst = 1'b1;
        start = 1'b0;
        num_words = 7'd0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);

        // Single word load
        pulse_start(7'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, byte_ready}, 32'd1);
        send_word(32'h00020820, 32'd0, 1'b0);
        wait_done();
        check("w1_writes", writes, 32'd1);
        check("w1_dones", done_cnt, 32'd1);

        // Three words back to back (start issued from RUN)
        pulse_start(7'd3);
        check("run_reinit", {31'd0, initialize}, 32'd1);
        check("run_recpu", {31'd0, cpu_rst}, 32'd1);
        send_word(32'h00020820, 32'd0, 1'b0);
        send_word(32'h00844022, 32'd4, 1'b0);
        send_word(32'h08000000, 32'd8, 1'b0);
        wait_done();
        check("w3_writes", writes, 32'd4);
        check("w3_dones", done_cnt, 32'd2);

        // Same program with byte_valid toggling
        pulse_start(7'd3);
        send_word(32'h00020820, 32'd0, 1'b1);
        send_word(32'h00844022, 32'd4, 1'b1);
        send_word(32'h08000000, 32'd8, 1'b1);
        wait_done();
        check("tog_writes", writes, 32'd7);
        check("tog_dones", done_cnt, 32'd3);

        // Oversized program rejected
        pulse_start(7'd65);
        repeat (3) @(negedge clk);
        check("big_error", {31'd0, error}, 32'd1);
        check("big_init", {31'd0, initialize}, 32'd1);
        check("big_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("big_busy", {31'd0, busy}, 32'd0);
        check("big_writes", writes, 32'd7);
        pulse_start(7'd1);
        check("err_clear", {31'd0, error}, 32'd0);
        send_word(32'h12345678, 32'd0, 1'b0);
        wait_done();

        // Reset in the middle of a word
        pulse_start(7'd2);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start(7'd1);
        send_word(32'h3c00ffff, 32'd0, 1'b0);
        wait_done();

        // Start during COLLECT is ignored
        d0 = done_cnt;
        w0 = writes;
        pulse_start(7'd2);
        send_byte(8'h11, 1'b0);
        pulse_start(7'd5);
        check("ign_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back({32'd0, 32'h11223344});
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_word(32'hCAFEF00D, 32'd4, 1'b0);
        wait_done();
        check("ign_writes", writes - w0, 32'd2);
        check("ign_dones", done_cnt - d0, 32'd1);

        // Start in RUN restores reset and base address next cycle
        check("pre_addr", instruction_initialize_address, 32'd4);
        pulse_start(7'd1);
        check("rr_init", {31'd0, initialize}, 32'd1);
        check("rr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rr_addr", instruction_initialize_address, 32'd0);
        send_word(32'h0BADC0DE, 32'd0, 1'b0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_cpu_program_loader
`default_nettype wire
